// File: rtl/fetch_stage.sv
// Instruction fetch with PC, imem req/valid handshake, skid buffer and IF/ID register.
// Latency: an instruction appears in IF/ID on the edge after its imem_valid.
// Backpressure: stall holds IF/ID and PC; a response caught under stall parks in the skid buffer.
module fetch_stage #(
    parameter int INSTR_W = 32,
    parameter int PC_W = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [8:0] NOP_OP = 9'b101
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               imem_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic               if_id_valid,
    output logic [8:0]         opcode
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [INSTR_W-1:0] NOP_INSTR = {NOP_OP, {(INSTR_W-9){1'b0}}};

    state_t              state;
    state_t              state_nxt;
    logic [PC_W-1:0]     pc;
    logic [PC_W-1:0]     drain_addr;
    logic [INSTR_W-1:0]  skid;
    logic [PC_W-1:0]     skid_pc;
    logic                skid_vld;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and memory request outputs. DRAIN keeps the abandoned address
    // on the bus until memory completes it, so the handshake stays legal.
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        imem_addr = pc;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (redirect) begin
                    state_nxt = imem_valid ? FETCH : DRAIN;
                end else if (imem_valid && stall) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (redirect || !stall) begin
                    state_nxt = FETCH;
                end
            end
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr;
                // Once the stale response lands, fetch resumes at the (possibly updated) pc.
                if (imem_valid) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // PC, skid buffer and IF/ID datapath; redirect outranks stall and normal flow.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            drain_addr  <= '0;
            skid        <= '0;
            skid_pc     <= '0;
            skid_vld    <= 1'b0;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
        end else if (redirect) begin
            pc          <= redirect_pc;
            if_id_valid <= 1'b0;
            skid_vld    <= 1'b0;
            if (state == FETCH && !imem_valid) begin
                drain_addr <= pc;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (imem_valid && !stall) begin
                        if_id_instr <= imem_data;
                        if_id_pc    <= pc;
                        if_id_valid <= 1'b1;
                        pc          <= pc + 1'b1;
                    end else if (imem_valid) begin
                        skid     <= imem_data;
                        skid_pc  <= pc;
                        skid_vld <= 1'b1;
                    end else if (!stall) begin
                        if_id_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_id_instr <= skid;
                        if_id_pc    <= skid_pc;
                        if_id_valid <= skid_vld;
                        skid_vld    <= 1'b0;
                        pc          <= pc + 1'b1;
                    end
                end
                DRAIN: begin
                    if_id_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Bubbles present the NOP opcode to the control unit.
    always_comb begin
        opcode = NOP_OP;
        if (if_id_valid) begin
            opcode = if_id_instr[INSTR_W-1 -: 9];
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_valid;
    logic [31:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic        if_id_valid;
    logic [8:0]  opcode;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .imem_valid  (imem_valid),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid),
        .opcode      (opcode)
    );

    // Memory model: word a holds opcode (a+1) mod 512 in the top 9 bits.
    logic [8:0] mem_op;
    always_comb begin
        mem_op    = imem_addr[8:0] + 9'd1;
        imem_data = {mem_op, 23'd0};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_if(input string tag, input logic vld, input logic [8:0] op, input logic [15:0] pc);
        chk({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, vld});
        chk({tag, "_opcode"}, {23'd0, opcode}, {23'd0, op});
        if (vld) chk({tag, "_pc"}, {16'd0, if_id_pc}, {16'd0, pc});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'd0; imem_valid = 1'b1;
        tick(); tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_instr", if_id_instr, 32'h0280_0000);
        chk("rst_pc", {16'd0, if_id_pc}, 32'd0);
        chk_if("rst", 1'b0, 9'd5, 16'd0);

        // Zero-wait fetches; first cycle after reset is IDLE.
        rst = 1'b0;
        tick();
        chk("idle_to_fetch_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", {16'd0, imem_addr}, 32'd0);
        chk_if("idle", 1'b0, 9'd5, 16'd0);
        tick(); chk_if("f0", 1'b1, 9'd1, 16'd0);
        tick(); chk_if("f1", 1'b1, 9'd2, 16'd1);
        chk("addr_2", {16'd0, imem_addr}, 32'd2);

        // Two wait cycles on address 2.
        imem_valid = 1'b0;
        tick(); chk_if("wait1", 1'b0, 9'd5, 16'd0);
        chk("wait1_addr", {16'd0, imem_addr}, 32'd2);
        tick(); chk_if("wait2", 1'b0, 9'd5, 16'd0);
        chk("wait2_addr", {16'd0, imem_addr}, 32'd2);
        chk("wait2_req", {31'd0, imem_req}, 32'd1);
        imem_valid = 1'b1;
        tick(); chk_if("f2", 1'b1, 9'd3, 16'd2);
        tick(); chk_if("f3", 1'b1, 9'd4, 16'd3);
        chk("addr_4", {16'd0, imem_addr}, 32'd4);

        // Stall as the response for address 4 returns: parked in skid, HOLD for 3 cycles.
        stall = 1'b1;
        tick(); chk_if("hold1", 1'b1, 9'd4, 16'd3);
        chk("hold1_req", {31'd0, imem_req}, 32'd0);
        tick(); chk_if("hold2", 1'b1, 9'd4, 16'd3);
        tick(); chk_if("hold3", 1'b1, 9'd4, 16'd3);
        chk("hold3_req", {31'd0, imem_req}, 32'd0);
        stall = 1'b0;
        tick(); chk_if("unskid", 1'b1, 9'd5, 16'd4);
        chk("resume_addr", {16'd0, imem_addr}, 32'd5);
        chk("resume_req", {31'd0, imem_req}, 32'd1);
        tick(); chk_if("f5", 1'b1, 9'd6, 16'd5);

        // Redirect to 0x40 while the request for 6 is outstanding.
        imem_valid = 1'b0;
        tick(); chk_if("pend6", 1'b0, 9'd5, 16'd0);
        redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        chk("drain_addr", {16'd0, imem_addr}, 32'd6);
        chk("drain_req", {31'd0, imem_req}, 32'd1);
        chk_if("drain", 1'b0, 9'd5, 16'd0);
        imem_valid = 1'b1;
        tick(); chk_if("drained", 1'b0, 9'd5, 16'd0);
        chk("redir_addr", {16'd0, imem_addr}, 32'h40);
        tick(); chk_if("f40", 1'b1, 9'h41, 16'h0040);

        // Redirect and stall together with IF/ID valid; response same cycle is dropped.
        redirect = 1'b1; stall = 1'b1; redirect_pc = 16'hFFFF;
        tick(); chk_if("redir_stall", 1'b0, 9'd5, 16'd0);
        chk("redir_stall_addr", {16'd0, imem_addr}, 32'hFFFF);
        redirect = 1'b0; stall = 1'b0;
        tick(); chk_if("fFFFF", 1'b1, 9'd0, 16'hFFFF);
        chk("wrap_addr", {16'd0, imem_addr}, 32'd0);
        tick(); chk_if("f0000", 1'b1, 9'd1, 16'h0000);

        // Reset while in HOLD.
        stall = 1'b1;
        tick(); chk("hold_req", {31'd0, imem_req}, 32'd0);
        rst = 1'b1;
        tick();
        chk_if("rst_hold", 1'b0, 9'd5, 16'd0);
        chk("rst_hold_req", {31'd0, imem_req}, 32'd0);
        chk("rst_hold_instr", if_id_instr, 32'h0280_0000);
        chk("rst_hold_pc", {16'd0, if_id_pc}, 32'd0);
        rst = 1'b0; stall = 1'b0;
        tick();
        chk("post_rst_addr", {16'd0, imem_addr}, 32'd0);
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
